// File: rtl/ram_pkg.sv
// Shared constants for the simple dual-port RAM family plus the parameter legality
// check that every RAM top evaluates at elaboration time.
package ram_pkg;

  localparam string PRIM_BLOCK       = "block";
  localparam string PRIM_DIST        = "distributed";
  localparam string PRIM_AUTO        = "auto";

  localparam string COLL_READ_FIRST  = "no";
  localparam string COLL_WRITE_FIRST = "write_first";

  function automatic bit params_legal(
    input int    mem_words,
    input int    addr_w,
    input int    data_w,
    input int    rd_lat,
    input string prim,
    input string coll
  );
    bit ok;
    ok = 1'b1;
    if (addr_w < 1 || addr_w > 31 || data_w < 1) ok = 1'b0;
    if (mem_words < 1) ok = 1'b0;
    if (addr_w >= 1 && addr_w <= 31 && longint'(mem_words) > (longint'(1) << addr_w)) ok = 1'b0;
    if (rd_lat < 1) ok = 1'b0;
    if (!(prim == PRIM_BLOCK || prim == PRIM_DIST || prim == PRIM_AUTO)) ok = 1'b0;
    if (!(coll == COLL_READ_FIRST || coll == COLL_WRITE_FIRST)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sdp_ram_rdpipe.sv
// Output shift register behind the RAM read stage: Depth stages of DataBusWidth bits,
// shifting every cycle, cleared by the synchronous reset.
module sdp_ram_rdpipe #(
  parameter int DataBusWidth = 8,
  parameter int Depth        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DataBusWidth-1:0] data_i,
  output logic [DataBusWidth-1:0] data_o
);

  logic [DataBusWidth-1:0] pipe_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign data_o = pipe_q[Depth-1];

endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: write-only port A, read-only port B, one clock,
// registered read data with ReadLatency cycles from re_b sample to r_data_b.
module sdp_ram
  import ram_pkg::*;
#(
  parameter int    MemSizeWords        = 32,
  parameter int    AddrBusWidth        = 5,
  parameter int    DataBusWidth        = 8,
  parameter string MemoryPrimitive     = "block",
  parameter string MemoryAddrCollision = "no",
  parameter int    ReadLatency         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddrBusWidth-1:0] addr_a,
  input  logic                    we_a,
  input  logic [DataBusWidth-1:0] w_data_a,
  input  logic [AddrBusWidth-1:0] addr_b,
  input  logic                    re_b,
  output logic [DataBusWidth-1:0] r_data_b
);

  if (!params_legal(MemSizeWords, AddrBusWidth, DataBusWidth, ReadLatency,
                    MemoryPrimitive, MemoryAddrCollision)) begin : g_param_check
    $error("sdp_ram: illegal parameter set");
  end

  localparam int                  IdxW       = (MemSizeWords > 1) ? $clog2(MemSizeWords) : 1;
  localparam logic [AddrBusWidth:0] MemLimit = (AddrBusWidth+1)'(MemSizeWords);
  localparam bit                  WriteFirst = (MemoryAddrCollision == COLL_WRITE_FIRST);

  // Contents start at zero and survive rst; only the read path is reset.
  (* ram_style = MemoryPrimitive *)
  logic [DataBusWidth-1:0] mem_q [MemSizeWords] = '{default: '0};

  logic [DataBusWidth-1:0] stage1_q;
  logic                    wr_ok;
  logic                    rd_in_range;
  logic                    collide;
  logic [IdxW-1:0]         wr_idx;
  logic [IdxW-1:0]         rd_idx;

  assign wr_ok       = we_a && ({1'b0, addr_a} < MemLimit);
  assign rd_in_range = {1'b0, addr_b} < MemLimit;
  assign collide     = wr_ok && (addr_a == addr_b);
  assign wr_idx      = addr_a[IdxW-1:0];
  assign rd_idx      = addr_b[IdxW-1:0];

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_idx] <= w_data_a;
  end

  // Non-blocking semantics give read-first; write-first forwards port A data.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
    end else if (re_b) begin
      if (!rd_in_range)               stage1_q <= '0;
      else if (WriteFirst && collide) stage1_q <= w_data_a;
      else                            stage1_q <= mem_q[rd_idx];
    end
  end

  if (ReadLatency == 1) begin : g_lat1
    assign r_data_b = stage1_q;
  end else begin : g_pipe
    sdp_ram_rdpipe #(
      .DataBusWidth(DataBusWidth),
      .Depth       (ReadLatency - 1)
    ) u_rdpipe (
      .clk   (clk),
      .rst   (rst),
      .data_i(stage1_q),
      .data_o(r_data_b)
    );
  end

endmodule

// File: tb/tb_sdp_ram.sv
// Bench for sdp_ram: four configurations share one stimulus stream and are compared
// every cycle against a history-based reference model, plus directed spot checks.
module tb_sdp_ram;

  localparam int NCFG      = 4;
  localparam int MAX_EDGES = 4096;

  // Configurations: 0 = lat1/read-first, 1 = lat1/write-first,
  //                 2 = lat3/read-first, 3 = 24 words/lat2/write-first.
  int cfg_lat  [NCFG] = '{1, 1, 3, 2};
  int cfg_size [NCFG] = '{32, 32, 32, 24};
  bit cfg_wf   [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic       clk;
  logic       rst;
  logic [4:0] addr_a;
  logic       we_a;
  logic [7:0] w_data_a;
  logic [4:0] addr_b;
  logic       re_b;
  logic [7:0] r_data [NCFG];

  int n_vec;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sdp_ram #(.MemSizeWords(32), .AddrBusWidth(5), .DataBusWidth(8), .MemoryPrimitive("block"),
            .MemoryAddrCollision("no"), .ReadLatency(1)) u_dut0 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .w_data_a(w_data_a),
    .addr_b(addr_b), .re_b(re_b), .r_data_b(r_data[0]));

  sdp_ram #(.MemSizeWords(32), .AddrBusWidth(5), .DataBusWidth(8), .MemoryPrimitive("block"),
            .MemoryAddrCollision("write_first"), .ReadLatency(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .w_data_a(w_data_a),
    .addr_b(addr_b), .re_b(re_b), .r_data_b(r_data[1]));

  sdp_ram #(.MemSizeWords(32), .AddrBusWidth(5), .DataBusWidth(8), .MemoryPrimitive("auto"),
            .MemoryAddrCollision("no"), .ReadLatency(3)) u_dut2 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .w_data_a(w_data_a),
    .addr_b(addr_b), .re_b(re_b), .r_data_b(r_data[2]));

  sdp_ram #(.MemSizeWords(24), .AddrBusWidth(5), .DataBusWidth(8), .MemoryPrimitive("distributed"),
            .MemoryAddrCollision("write_first"), .ReadLatency(2)) u_dut3 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .w_data_a(w_data_a),
    .addr_b(addr_b), .re_b(re_b), .r_data_b(r_data[3]));

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] mem_m   [32];
  logic [7:0] s1_hist [NCFG][MAX_EDGES];
  bit         rst_hist[MAX_EDGES];
  int         edge_n;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %02h expected %02h", tag, edge_n, got, exp);
    end
  endtask

  // r_data_b after edge n is the read result latched at edge n-L+1, unless a reset
  // landed on one of the edges since then, which flushes it to zero.
  function automatic logic [7:0] expected_out(input int c, input int n);
    int src;
    src = n - cfg_lat[c] + 1;
    for (int m = src + 1; m <= n; m++)
      if (rst_hist[m]) return 8'h00;
    return s1_hist[c][src];
  endfunction

  task automatic step();
    logic [7:0] prev;
    logic [7:0] nv;
    @(posedge clk);
    for (int c = 0; c < NCFG; c++) begin
      prev = (edge_n > 0) ? s1_hist[c][edge_n-1] : 8'h00;
      nv   = prev;
      if (rst)                            nv = 8'h00;
      else if (re_b) begin
        if (int'(addr_b) >= cfg_size[c])  nv = 8'h00;
        else if (cfg_wf[c] && we_a && addr_a == addr_b) nv = w_data_a;
        else                              nv = mem_m[addr_b];
      end
      s1_hist[c][edge_n] = nv;
    end
    rst_hist[edge_n] = rst;
    if (we_a) mem_m[addr_a] = w_data_a;
    #1;
    if (edge_n >= 3) begin
      for (int c = 0; c < NCFG; c++)
        check_val($sformatf("model_cfg%0d", c), r_data[c], expected_out(c, edge_n));
    end
    edge_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic we, input logic [4:0] aa,
                       input logic [7:0] wd, input logic re, input logic [4:0] ab);
    rst = r; we_a = we; addr_a = aa; w_data_a = wd; re_b = re; addr_b = ab;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec  = 0;
    n_err  = 0;
    edge_n = 0;
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;

    drive(1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00);
    repeat (4) step();
    check_val("reset_out_lat1", r_data[0], 8'h00);
    check_val("reset_out_lat3", r_data[2], 8'h00);

    // Initial read of an unwritten word
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1B);
    step();
    check_val("init_read", r_data[0], 8'h00);

    // Write C5 to 1B for two edges while reading it
    drive(1'b0, 1'b1, 5'h1B, 8'hC5, 1'b1, 5'h1B);
    repeat (2) step();
    check_val("wr_rd", r_data[0], 8'hC5);

    // Port A don't-care period
    drive(1'b0, 1'b0, 'x, 'x, 1'b0, 5'h1B);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("x_period_hold", r_data[0], 8'hC5);
    end
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1B);
    step();
    check_val("reread", r_data[0], 8'hC5);

    // Hold with re_b low
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 5'h00);
    step();
    check_val("hold", r_data[0], 8'hC5);

    // Collision on address 05
    drive(1'b0, 1'b1, 5'h05, 8'h11, 1'b0, 5'h00);
    step();
    drive(1'b0, 1'b1, 5'h05, 8'h22, 1'b1, 5'h05);
    step();
    check_val("coll_read_first", r_data[0], 8'h11);
    check_val("coll_write_first", r_data[1], 8'h22);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h05);
    step();
    check_val("coll_next_read", r_data[0], 8'h22);

    // Reset clears the read path only
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1B);
    step();
    check_val("pre_rst", r_data[0], 8'hC5);
    drive(1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 5'h1B);
    step();
    check_val("rst_clears_out", r_data[0], 8'h00);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1B);
    step();
    check_val("rst_keeps_mem", r_data[0], 8'hC5);

    // Latency-3 timing: flush with reads of 00, then read 1B at edge k
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h00);
    repeat (3) step();
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1B);
    step();
    check_val("lat3_edge_k", r_data[2], 8'h00);
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h00);
    step();
    check_val("lat3_edge_k1", r_data[2], 8'h00);
    step();
    check_val("lat3_edge_k2", r_data[2], 8'hC5);

    // Out-of-range read on the 24-word instance (lat 2)
    drive(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 5'h1B);
    repeat (2) step();
    check_val("oor_read_zero", r_data[3], 8'h00);

    // Randomized traffic with biased collisions and occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] aa;
      logic [4:0] ab;
      aa = 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), aa,
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ab);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
